// File: rtl/aqua_pkg.sv
// rtl/aqua_pkg.sv - shared ALU issue types and scheduler sizing
package aqua_pkg;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
   } operator_e;

   typedef struct packed {
      operator_e   instr;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      logic [4:0]  rd_addr;
      logic        fwd_en;
      logic        valid;
   } alu_issue_s;

   localparam int ALU_SCHED_DEPTH = 4;

endpackage

// File: rtl/alu_issue_fifo.sv
// rtl/alu_issue_fifo.sv - circular packet buffer, dual push / single pop
module alu_issue_fifo
   import aqua_pkg::*;
#(
   parameter int DEPTH = ALU_SCHED_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic [1:0]    push_cnt,
   input  alu_issue_s    push_pkg [2],
   input  logic          pop,
   output alu_issue_s    head_pkg,
   output logic [OW-1:0] occupancy
);

   alu_issue_s    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          hold_off;

   assign hold_off = i_rst || i_clr;
   assign head_pkg = mem[rd_ptr];

   // Storage is not reset; entries are only read while occupancy is non-zero.
   always_ff @(posedge i_clk) begin
      if (!hold_off) begin
         if (push_cnt != 2'd0)
            mem[wr_ptr] <= push_pkg[0];
         if (push_cnt == 2'd2)
            mem[wr_ptr + PW'(1)] <= push_pkg[1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (hold_off) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         wr_ptr    <= wr_ptr + PW'(push_cnt);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         occupancy <= occupancy + OW'(push_cnt) - OW'(pop);
      end
   end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - in-order 2-to-1 ALU issue scheduler with bypass
module alu_issue_sched
   import aqua_pkg::*;
#(
   parameter int DEPTH = ALU_SCHED_DEPTH,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  alu_issue_s    i_slot0_pkg,
   input  alu_issue_s    i_slot1_pkg,
   input  logic          i_flush,
   input  logic          i_buff_full,
   output alu_issue_s    o_abt_alu_pkg,
   output logic          o_stall,
   output logic [OW-1:0] o_occupancy
);

   logic       take;
   alu_issue_s acc_pkg  [2];
   logic [1:0] acc_cnt;
   alu_issue_s push_pkg [2];
   logic [1:0] push_cnt;
   logic       pop;
   alu_issue_s head_pkg;
   alu_issue_s out_next;

   // Stall looks only at registered occupancy, leaving room for two pushes.
   assign o_stall = (o_occupancy > OW'(DEPTH - 2));
   assign take    = !o_stall && !i_flush;

   // Compact the accepted slots so that acc_pkg[0] is always the oldest.
   always_comb begin
      acc_cnt    = 2'd0;
      acc_pkg[0] = '0;
      acc_pkg[1] = '0;
      if (take) begin
         if (i_slot0_pkg.valid) begin
            acc_pkg[0] = i_slot0_pkg;
            if (i_slot1_pkg.valid) begin
               acc_pkg[1] = i_slot1_pkg;
               acc_cnt    = 2'd2;
            end else begin
               acc_cnt    = 2'd1;
            end
         end else if (i_slot1_pkg.valid) begin
            acc_pkg[0] = i_slot1_pkg;
            acc_cnt    = 2'd1;
         end
      end
   end

   always_comb begin
      pop         = 1'b0;
      push_cnt    = acc_cnt;
      push_pkg[0] = acc_pkg[0];
      push_pkg[1] = acc_pkg[1];
      out_next    = o_abt_alu_pkg;
      if (!i_buff_full) begin
         if (o_occupancy != '0) begin
            pop      = 1'b1;
            out_next = head_pkg;
         end else if (acc_cnt != 2'd0) begin
            out_next    = acc_pkg[0];
            push_pkg[0] = acc_pkg[1];
            push_pkg[1] = '0;
            push_cnt    = acc_cnt - 2'd1;
         end else begin
            out_next = '0;
         end
      end
   end

   alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (i_flush),
      .push_cnt  (push_cnt),
      .push_pkg  (push_pkg),
      .pop       (pop),
      .head_pkg  (head_pkg),
      .occupancy (o_occupancy)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush)
         o_abt_alu_pkg <= '0;
      else
         o_abt_alu_pkg <= out_next;
   end

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - self-checking bench for alu_issue_sched
module tb_alu_issue_sched;
   import aqua_pkg::*;

   localparam int DEPTH = ALU_SCHED_DEPTH;

   logic       clk = 1'b0;
   logic       rst;
   alu_issue_s s0, s1;
   logic       flush, bf;
   alu_issue_s out_pkg;
   logic       stall;
   logic [$clog2(DEPTH+1)-1:0] occ;

   int n_chk  = 0;
   int n_fail = 0;

   alu_issue_s mq[$];
   alu_issue_s mout;

   always #5 clk = ~clk;

   alu_issue_sched #(.DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_slot0_pkg   (s0),
      .i_slot1_pkg   (s1),
      .i_flush       (flush),
      .i_buff_full   (bf),
      .o_abt_alu_pkg (out_pkg),
      .o_stall       (stall),
      .o_occupancy   (occ)
   );

   function automatic alu_issue_s mk(operator_e op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
      alu_issue_s p;
      p = '0;
      p.instr = op; p.operand_a = a; p.operand_b = b; p.rd_addr = rd; p.valid = 1'b1;
      return p;
   endfunction

   // Reference: program-ordered list of waiting packets plus the output slot.
   task automatic tick();
      alu_issue_s acc[$];
      bit stall_m;
      stall_m = mq.size() > DEPTH - 2;
      if (rst || flush) begin
         mq.delete();
         mout = '0;
      end else begin
         if (!stall_m) begin
            if (s0.valid) acc.push_back(s0);
            if (s1.valid) acc.push_back(s1);
         end
         foreach (acc[i]) mq.push_back(acc[i]);
         if (!bf) mout = (mq.size() > 0) ? mq.pop_front() : alu_issue_s'('0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_flush();
      s0 = '0; s1 = '0; bf = 0; rst = 0; flush = 1;
      tick();
      flush = 0;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; bf = 0;
      s0 = mk(OP_ADD, 5, 3, 1);
      s1 = mk(OP_ADD, 5, 3, 2);
      for (int c = 0; c < 2; c++) begin
         tick();
         n_chk++;
         if ({out_pkg, occ, stall} !== '0) begin
            $display("FAIL reset_state cyc%0d got out=%h occ=%0d stall=%0b want all zero", c, out_pkg, occ, stall);
            n_fail++;
         end
      end
      rst = 0;
      tick();
      n_chk++;
      if (out_pkg !== mk(OP_ADD, 5, 3, 1) || occ !== 1) begin
         $display("FAIL reset_release got out=%h occ=%0d want %h occ=1", out_pkg, occ, mk(OP_ADD, 5, 3, 1));
         n_fail++;
      end
      s0 = '0; s1 = '0;
      tick();
      n_chk++;
      if (out_pkg !== mk(OP_ADD, 5, 3, 2) || occ !== 0) begin
         $display("FAIL reset_second got out=%h occ=%0d want %h occ=0", out_pkg, occ, mk(OP_ADD, 5, 3, 2));
         n_fail++;
      end
   endtask

   task automatic test_bypass();
      idle_flush();
      s0 = mk(OP_SUB, 32'h10, 32'h4, 7);
      tick();
      n_chk++;
      if (out_pkg !== mk(OP_SUB, 32'h10, 32'h4, 7) || occ !== 0) begin
         $display("FAIL bypass_out got %h occ=%0d want %h occ=0", out_pkg, occ, mk(OP_SUB, 32'h10, 32'h4, 7));
         n_fail++;
      end
      s0 = '0;
      tick();
      n_chk++;
      if (out_pkg.valid !== 1'b0 || occ !== 0) begin
         $display("FAIL bypass_after got valid=%0b occ=%0d want valid=0 occ=0", out_pkg.valid, occ);
         n_fail++;
      end
   endtask

   task automatic test_dual_issue();
      int exp_rd[6] = '{1, 2, 1, 2, 1, 2};
      int exp_occ[6] = '{1, 2, 3, 2, 1, 0};
      idle_flush();
      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            s0 = mk(OP_ADD, 32'(c), 1, 1);
            s1 = mk(OP_XOR, 32'(c), 2, 2);
         end else begin
            s0 = '0; s1 = '0;
         end
         tick();
         n_chk++;
         if (out_pkg.valid !== 1'b1 || int'(out_pkg.rd_addr) != exp_rd[c] || int'(occ) != exp_occ[c]
             || stall !== (exp_occ[c] > DEPTH - 2)) begin
            $display("FAIL dual_seq cyc%0d got v=%0b rd=%0d occ=%0d stall=%0b want v=1 rd=%0d occ=%0d",
                     c, out_pkg.valid, out_pkg.rd_addr, occ, stall, exp_rd[c], exp_occ[c]);
            n_fail++;
         end
      end
      tick();
      n_chk++;
      if (out_pkg.valid !== 1'b0 || occ !== 0) begin
         $display("FAIL dual_drain got valid=%0b occ=%0d want 0 0", out_pkg.valid, occ);
         n_fail++;
      end
   endtask

   task automatic test_back_pressure();
      alu_issue_s slt_p, sll_p, sra_p;
      slt_p = mk(OP_SLT, 9, 8, 5);
      sll_p = mk(OP_SLL, 1, 2, 3);
      sra_p = mk(OP_SRA, 3, 1, 4);
      idle_flush();
      s0 = slt_p;
      tick();
      s0 = sll_p; s1 = sra_p; bf = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         s0 = '0; s1 = '0;
         n_chk++;
         if (out_pkg !== slt_p || occ !== 2) begin
            $display("FAIL bp_hold cyc%0d got %h occ=%0d want %h occ=2", c, out_pkg, occ, slt_p);
            n_fail++;
         end
      end
      bf = 0;
      tick();
      n_chk++;
      if (out_pkg !== sll_p) begin
         $display("FAIL bp_release1 got %h want %h", out_pkg, sll_p);
         n_fail++;
      end
      tick();
      n_chk++;
      if (out_pkg !== sra_p || occ !== 0) begin
         $display("FAIL bp_release2 got %h occ=%0d want %h occ=0", out_pkg, occ, sra_p);
         n_fail++;
      end
   endtask

   task automatic test_flush();
      idle_flush();
      for (int c = 0; c < 3; c++) begin
         s0 = mk(OP_AND, 32'(c), 0, 10);
         s1 = mk(OP_OR, 32'(c), 0, 11);
         tick();
      end
      n_chk++;
      if (occ !== 3 || stall !== 1'b1) begin
         $display("FAIL flush_setup got occ=%0d stall=%0b want occ=3 stall=1", occ, stall);
         n_fail++;
      end
      s0 = mk(OP_SRL, 7, 7, 20);
      s1 = mk(OP_SLTU, 7, 7, 21);
      flush = 1;
      tick();
      flush = 0; s0 = '0; s1 = '0;
      n_chk++;
      if ({out_pkg, occ, stall} !== '0) begin
         $display("FAIL flush_state got out=%h occ=%0d stall=%0b want all zero", out_pkg, occ, stall);
         n_fail++;
      end
      tick();
      n_chk++;
      if (out_pkg.valid !== 1'b0 || occ !== 0) begin
         $display("FAIL flush_dropped got valid=%0b rd=%0d occ=%0d want valid=0 occ=0", out_pkg.valid, out_pkg.rd_addr, occ);
         n_fail++;
      end
   endtask

   task automatic test_random();
      alu_issue_s p;
      idle_flush();
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            p = '0;
            if ($urandom_range(0, 9) < 7) begin
               p = mk(operator_e'($urandom_range(0, 9)), $urandom, $urandom, 5'($urandom));
               p.fwd_en = 1'($urandom);
            end
            if (k == 0) s0 = p; else s1 = p;
         end
         flush = ($urandom_range(0, 29) == 0);
         bf    = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         tick();
         n_chk++;
         if (out_pkg !== mout) begin
            $display("FAIL rand_out cyc%0d got %h want %h", c, out_pkg, mout);
            n_fail++;
         end
         n_chk++;
         if (int'(occ) != mq.size() || stall !== (mq.size() > DEPTH - 2) || int'(occ) > DEPTH) begin
            $display("FAIL rand_occ cyc%0d got occ=%0d stall=%0b want occ=%0d", c, occ, stall, mq.size());
            n_fail++;
         end
      end
      rst = 0; flush = 0; bf = 0;
   endtask

   initial begin
      rst = 1; flush = 0; bf = 0; s0 = '0; s1 = '0;
      mout = '0;
      #1;
      test_reset();
      test_bypass();
      test_dual_issue();
      test_back_pressure();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
